l2_word_responder: RTL

L2_WORD_RESPONDER -- requirements
Module: l2_word_responder

---
 rtl/l2_word_responder.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/l2_word_responder.sv
// Single-port word memory behind the L2 bus handshake: FREE -> BUSY (LATENCY cycles) -> ACCESS.
// Misaligned, out-of-window or ambiguous requests go to ERROR for one cycle.
module l2_word_responder #(
  parameter int unsigned LATENCY   = 4,
  parameter int unsigned MEM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        l2REN,
  input  logic        l2WEN,
  input  logic [31:0] l2addr,
  input  logic [31:0] l2store,
  input  logic [3:0]  l2_byte_en,
  output logic [31:0] l2load,
  output logic [1:0]  l2state,
  output logic        l2error
);

  typedef enum logic [1:0] {
    L2_FREE   = 2'd0,
    L2_BUSY   = 2'd1,
    L2_ACCESS = 2'd2,
    L2_ERROR  = 2'd3
  } l2_state_t;

  localparam int unsigned AW     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [33:0] SPAN   = 34'(MEM_WORDS) * 34'd4;
  localparam logic [3:0]  LAT_M1 = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  l2_state_t         r_state, w_state_d;
  logic [3:0]        r_cnt, w_cnt_d;
  logic [31:0]       r_load;
  logic              r_is_write;
  logic [AW-1:0]     r_idx;
  logic [31:0]       r_data;
  logic [3:0]        r_be;
  logic [31:0]       r_mem [MEM_WORDS] = '{default: 32'h0};

  logic [32:0]       w_offset;
  logic              w_in_range;
  logic              w_req_ok;
  logic              w_line;
  logic              w_cap;
  logic              w_wr_en;
  logic              w_rd_en;
  logic [AW-1:0]     w_idx;
  logic [31:0]       w_wr_data;
  logic [3:0]        w_wr_be;

  // 33-bit offset so an address below BASE_ADDR shows up as a borrow.
  assign w_offset   = {1'b0, l2addr} - {1'b0, BASE_ADDR};
  assign w_in_range = !w_offset[32] && ({1'b0, w_offset} < SPAN);
  assign w_req_ok   = (l2REN ^ l2WEN) && (l2addr[1:0] == 2'b00) && w_in_range;
  assign w_line     = r_is_write ? l2WEN : l2REN;

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_cap     = 1'b0;
    w_wr_en   = 1'b0;
    w_rd_en   = 1'b0;
    w_idx     = r_idx;
    w_wr_data = r_data;
    w_wr_be   = r_be;
    unique case (r_state)
      L2_FREE: begin
        if (l2REN || l2WEN) begin
          if (!w_req_ok) begin
            w_state_d = L2_ERROR;
          end else if (LATENCY == 0) begin
            w_state_d = L2_ACCESS;
            w_idx     = w_offset[AW+1:2];
            w_wr_data = l2store;
            w_wr_be   = l2_byte_en;
            w_wr_en   = l2WEN && !RST;
            w_rd_en   = l2REN;
          end else begin
            w_state_d = L2_BUSY;
            w_cnt_d   = LAT_M1;
            w_cap     = 1'b1;
          end
        end
      end
      L2_BUSY: begin
        if (!w_line) begin
          w_state_d = L2_FREE;
        end else if (r_cnt == 4'd0) begin
          w_state_d = L2_ACCESS;
          w_wr_en   = r_is_write && !RST;
          w_rd_en   = !r_is_write;
        end else begin
          w_cnt_d = r_cnt - 4'd1;
        end
      end
      L2_ACCESS: w_state_d = L2_FREE;
      L2_ERROR:  w_state_d = L2_FREE;
      default:   w_state_d = L2_FREE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= L2_FREE;
      r_cnt      <= 4'd0;
      r_load     <= 32'h0;
      r_is_write <= 1'b0;
      r_idx      <= '0;
      r_data     <= 32'h0;
      r_be       <= 4'h0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      if (w_rd_en) begin
        r_load <= r_mem[w_idx];
      end
      if (w_cap) begin
        r_is_write <= l2WEN;
        r_idx      <= w_offset[AW+1:2];
        r_data     <= l2store;
        r_be       <= l2_byte_en;
      end
    end
  end

  // Storage is deliberately outside the reset domain; contents survive RST.
  always_ff @(posedge CLK) begin
    if (w_wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (w_wr_be[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_wr_data[8*i +: 8];
        end
      end
    end
  end

  assign l2load  = r_load;
  assign l2state = r_state;
  assign l2error = (r_state == L2_ERROR);

endmodule
